// File: rtl/cache_fill_responder_if.sv
// cache_fill_responder_if
//   Bundles the two buses around the line-fill responder.
//   Cache side : sdram_req/sdram_rw/sdram_addr/data_to_sdram/sdram_uds/sdram_lds in,
//                sdram_fill/data_from_sdram/sdram_wr_ack back to the cache.
//   Memory side: mem_req/mem_we/mem_addr/mem_wdata/mem_ube/mem_lbe out,
//                mem_ack/mem_rdata back from the single-word memory port.
//   Modport slave is the responder itself; modport master is the environment
//   (cache plus memory) that surrounds it.
interface cache_fill_responder_if #(
  parameter int AW = 32
);

  logic          sdram_req;
  logic          sdram_rw;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   data_to_sdram;
  logic          sdram_uds;
  logic          sdram_lds;
  logic          sdram_fill;
  logic [15:0]   data_from_sdram;
  logic          sdram_wr_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ube;
  logic          mem_lbe;
  logic          mem_ack;
  logic [15:0]   mem_rdata;

  modport slave (
    input  sdram_req, sdram_rw, sdram_addr, data_to_sdram, sdram_uds, sdram_lds,
    output sdram_fill, data_from_sdram, sdram_wr_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_ube, mem_lbe,
    input  mem_ack, mem_rdata
  );

  modport master (
    output sdram_req, sdram_rw, sdram_addr, data_to_sdram, sdram_uds, sdram_lds,
    input  sdram_fill, data_from_sdram, sdram_wr_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_ube, mem_lbe,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cache_fill_responder.sv
// cache_fill_responder
//   Responder end of the cache line-fill protocol. A read request fetches the
//   addressed 4-word line critical-word-first, one memory handshake per word,
//   into a local buffer, then replays it as a 4-cycle burst whose first beat
//   is marked by a one-cycle sdram_fill strobe. A write request forwards one
//   16-bit word with its byte enables and answers with a one-cycle sdram_wr_ack.
// Ports
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : cache_fill_responder_if.slave (cache side and memory side)
module cache_fill_responder #(
  parameter int AW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_fill_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BURST,
    WRITE,
    WRACK,
    DRAIN
  } state_e;

  state_e        state_q;
  logic [AW-1:3] line_q;
  logic [1:0]    critWord_q;
  logic [1:0]    fetchCnt_q;
  logic [1:0]    beatCnt_q;
  logic [15:0]   lineBuf_q [4];

  logic          fill_q;
  logic [15:0]   readData_q;
  logic          wrAck_q;
  logic          memReq_q;
  logic          memWe_q;
  logic [AW-1:0] memAddr_q;
  logic [15:0]   memWdata_q;
  logic          memUbe_q;
  logic          memLbe_q;

  // Word index of the next fetch; 2-bit add so it wraps inside the line and
  // the line bits are never carried into.
  logic [1:0] nextWord;
  assign nextWord = critWord_q + fetchCnt_q;

  // The whole controller: every bus output is a register updated here, so the
  // asynchronous reset drops mem_req and sdram_fill without waiting for a clock.
  // The buffer is filled in fetch order, so slot 0 always holds the critical
  // word and replaying slots 0..3 gives critical-word-first order for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      critWord_q <= '0;
      fetchCnt_q <= '0;
      beatCnt_q  <= '0;
      for (int i = 0; i < 4; i++) lineBuf_q[i] <= '0;
      fill_q     <= 1'b0;
      readData_q <= '0;
      wrAck_q    <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memUbe_q   <= 1'b0;
      memLbe_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sdram_req) begin
            line_q     <= bus.sdram_addr[AW-1:3];
            critWord_q <= bus.sdram_addr[2:1];
            fetchCnt_q <= '0;
            // First fetch address and the write address share the same form.
            memReq_q   <= 1'b1;
            memAddr_q  <= {bus.sdram_addr[AW-1:1], 1'b0};
            memWe_q    <= ~bus.sdram_rw;
            memWdata_q <= bus.data_to_sdram;
            memUbe_q   <= ~bus.sdram_rw & bus.sdram_uds;
            memLbe_q   <= ~bus.sdram_rw & bus.sdram_lds;
            state_q    <= bus.sdram_rw ? FETCH : WRITE;
          end
        end

        FETCH: begin
          if (memReq_q && bus.mem_ack) begin
            lineBuf_q[fetchCnt_q] <= bus.mem_rdata;
            memReq_q   <= 1'b0;
            fetchCnt_q <= fetchCnt_q + 2'd1;
            if (fetchCnt_q == 2'd3) begin
              // Beat 0 leaves on the same edge that stores the last word.
              state_q    <= BURST;
              fill_q     <= 1'b1;
              readData_q <= lineBuf_q[0];
              beatCnt_q  <= 2'd1;
            end
          end else if (!memReq_q) begin
            // One idle cycle between words, then request the next one.
            memReq_q  <= 1'b1;
            memAddr_q <= {line_q, nextWord, 1'b0};
          end
        end

        BURST: begin
          fill_q     <= 1'b0;
          readData_q <= lineBuf_q[beatCnt_q];
          beatCnt_q  <= beatCnt_q + 2'd1;
          if (beatCnt_q == 2'd3) begin
            state_q <= DRAIN;
          end
        end

        WRITE: begin
          if (memReq_q && bus.mem_ack) begin
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            wrAck_q  <= 1'b1;
            state_q  <= WRACK;
          end
        end

        WRACK: begin
          wrAck_q <= 1'b0;
          state_q <= DRAIN;
        end

        DRAIN: begin
          // A request still held from the finished transaction must not be
          // taken as a new one.
          if (!bus.sdram_req) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sdram_fill      = fill_q;
  assign bus.data_from_sdram = readData_q;
  assign bus.sdram_wr_ack    = wrAck_q;
  assign bus.mem_req         = memReq_q;
  assign bus.mem_we          = memWe_q;
  assign bus.mem_addr        = memAddr_q;
  assign bus.mem_wdata       = memWdata_q;
  assign bus.mem_ube         = memUbe_q;
  assign bus.mem_lbe         = memLbe_q;

endmodule
